hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 149 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-subtract step per cycle; results are written 32 cycles after accept.
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        in_signed;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next, iter_next, mul_res;
  logic [31:0] quo, rem, quo_res, rem_res;

  // Signed ops run on magnitudes; signs are reapplied when the result is written.
  assign in_signed = ~op[0];
  assign rs_mag    = (in_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign rt_mag    = (in_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[32]) begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end
    iter_next = div_q ? div_next : mul_next;
    mul_res   = (neg_a_q ^ neg_b_q) ? (64'd0 - iter_next) : iter_next;
    quo       = iter_next[31:0];
    rem       = iter_next[63:32];
    quo_res   = (neg_a_q ^ neg_b_q) ? (32'd0 - quo) : quo;
    rem_res   = neg_a_q ? (32'd0 - rem) : rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    rs_d    = rs_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = 5'd0;
          div_d   = op[1];
          neg_a_d = in_signed & rs_val[31];
          neg_b_d = in_signed & rt_val[31];
          rs_d    = rs_val;
          // Multiply: acc low half holds the multiplier. Divide: it holds the dividend.
          if (op[1]) begin
            b_d   = rt_mag;
            acc_d = {32'd0, rs_mag};
          end else begin
            b_d   = rs_mag;
            acc_d = {32'd0, rt_mag};
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      StRun: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!div_q) begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
          end else if (b_q == 32'd0) begin
            hi_d = rs_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      rs_q    <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      rs_q    <= rs_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized self-checking bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic [31:0] HI, LO;
  logic        busy, done;

  int n_checks = 0;
  int n_errs   = 0;

  hilo_muldiv dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .HI     (HI),
    .LO     (LO),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      2'd0: begin
        q = sa * sb;
        p = q;
      end
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return p;
  endfunction

  // Caller is 1 time unit after a rising edge with the DUT idle (or in its done cycle).
  task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, output logic [63:0] res);
    logic [63:0] pre;
    int          bad;
    pre    = {HI, LO};
    start  = 1'b1;
    op     = mop;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    op     = 2'($urandom_range(0, 3));
    check("busy_e0", 64'(busy), 64'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (disturb && k == 5) begin
        start = 1'b1;
        op    = 2'd0;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h1234_5678;
      end else if (disturb && k == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      @(posedge clk); #1;
      if (k < 32 && (busy !== 1'b1 || done !== 1'b0 || {HI, LO} !== pre)) bad++;
    end
    check("run_stable", 64'(bad), 64'd0);
    check("busy_end", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    res = {HI, LO};
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] res;
    logic [31:0] a, b, hold;
    logic [1:0]  mop;
    int          bad;

    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; rs_val = 32'd0; rt_val = 32'd0; wdata = 32'd0;
    #1 reset = 1'b1;
    #1;
    check("reset_state", {HI, LO, 30'd0, busy, done}, 96'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res);
    check("multu_max", res, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    check("done_single", 64'(done), 64'd0);

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, res);
    check("mult_neg", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, res);
    check("div_neg", res, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd100, 32'd0, 1'b0, res);
    check("divu_zero", res, {32'd100, 32'hFFFF_FFFF});
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res);
    check("div_ovf", res, {32'd0, 32'h8000_0000});
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, res);
    check("div_zero_s", res, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    run_op(2'd3, 32'd9, 32'd4, 1'b1, res);
    check("ignore_busy", res, {32'd1, 32'd2});
    @(posedge clk); #1;
    check("no_queue", 64'(busy), 64'd0);

    // Back-to-back random operations; each start lands in the previous done cycle.
    for (int i = 0; i < 40; i++) begin
      mop = 2'($urandom_range(0, 3));
      a   = pick();
      b   = pick();
      run_op(mop, a, b, 1'b0, res);
      check($sformatf("rand%0d_op%0d", i, mop), res, model(mop, a, b));
    end
    @(posedge clk); #1;

    hold  = HI;
    mtlo  = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mtlo  = 1'b0;
    check("mtlo", {HI, LO}, {hold, 32'hCAFE_F00D});
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h0BAD_BEEF;
    @(posedge clk); #1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    check("mthi_mtlo", {HI, LO}, {32'h0BAD_BEEF, 32'h0BAD_BEEF});

    // Start wins over mthi in the accepting cycle.
    start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd5;
    mthi  = 1'b1; wdata = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("start_prio", {HI, LO}, 64'd15);

    start = 1'b1; op = 2'd0; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_run", {HI, LO, 30'd0, busy, done}, 96'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || {HI, LO} !== 64'd0) bad++;
    end
    check("abandon", 64'(bad), 64'd0);

    run_op(2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, res);
    check("after_reset", res, 64'd15);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
